// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mlp_pkg
// Description : Shared geometry, widths and FSM encoding for the MLP pixel path.
// Revision    : 1.0 - initial release
// ============================================================================
package mlp_pkg;

    localparam int IMG_W      = 28;
    localparam int IMG_H      = 28;
    localparam int RESOLUTION = 8;

    localparam int AVG_W      = IMG_W / 2;
    localparam int AVG_H      = IMG_H / 2;
    localparam int AVG_PIX    = AVG_W * AVG_H;

    localparam int HL_NEURONS = 64;
    localparam int OL_NEURONS = 10;

    localparam int COL_W      = $clog2(IMG_W);
    localparam int ROW_W      = $clog2(IMG_H);
    localparam int PAIR_W     = $clog2(AVG_W);
    localparam int BAND_W     = $clog2(AVG_H);
    localparam int K_W        = $clog2(AVG_PIX);
    localparam int PIX_BUS_W  = RESOLUTION * AVG_PIX;

    typedef logic [0:0] state_t;
    localparam state_t ST_FILL = 1'b0;
    localparam state_t ST_HOLD = 1'b1;

    // Row-major index of a pooled output from its 2x2 block coordinates.
    function automatic logic [K_W-1:0] pool_index(
        input logic [BAND_W-1:0] band,
        input logic [PAIR_W-1:0] pair
    );
        return K_W'(band) * K_W'(AVG_W) + K_W'(pair);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_frame_assembler_if.sv
`default_nettype none
// ============================================================================
// Interface   : pixel_frame_assembler_if
// Description : Pixel stream input and pooled-frame output of the assembler.
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_frame_assembler_if;
    import mlp_pkg::*;

    logic signed [RESOLUTION-1:0] s_pixel;
    logic                         s_valid;
    logic                         s_last;
    logic                         s_ready;
    logic [PIX_BUS_W-1:0]         pixels;
    logic                         frame_valid;
    logic                         frame_ready;
    logic                         frame_err;

    modport master (
        output s_pixel, s_valid, s_last, frame_ready,
        input  s_ready, pixels, frame_valid, frame_err
    );

    modport slave (
        input  s_pixel, s_valid, s_last, frame_ready,
        output s_ready, pixels, frame_valid, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/pixel_frame_assembler_pool_sum_unit.sv
`default_nettype none
// ============================================================================
// Module      : pool_sum_unit
// Description : Signed 2x2 sum and divide-by-four. Floor by default; round half
//               up when POOL_ROUND_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_sum_unit
    import mlp_pkg::*;
(
    input  wire logic signed [RESOLUTION:0]   i_psum,
    input  wire logic signed [RESOLUTION-1:0] i_a,
    input  wire logic signed [RESOLUTION-1:0] i_b,
    output logic signed [RESOLUTION-1:0]      o_pool
);

    logic signed [RESOLUTION+1:0] w_sum;
    logic signed [RESOLUTION+1:0] w_biased;
    logic                         w_unused_frac;

    assign w_sum = {i_psum[RESOLUTION], i_psum}
                 + {{2{i_a[RESOLUTION-1]}}, i_a}
                 + {{2{i_b[RESOLUTION-1]}}, i_b};

`ifdef POOL_ROUND_EN
    localparam logic signed [RESOLUTION+1:0] C_HALF = 2;
    assign w_biased = w_sum + C_HALF;
`else
    assign w_biased = w_sum;
`endif

    // Dropping the two LSBs of a sign-extended value is an arithmetic >>>2.
    assign o_pool        = w_biased[RESOLUTION+1:2];
    assign w_unused_frac = ^w_biased[1:0];

endmodule
`default_nettype wire

// File: rtl/pixel_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module      : pixel_frame_assembler
// Description : Collects a row-major pixel stream, 2x2-average pools it and
//               presents the frame with a valid/ready handshake.
//               Optional build macro: POOL_ROUND_EN (round half up pooling).
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_frame_assembler
    import mlp_pkg::*;
(
    input  wire                    clk,
    input  wire                    reset,
    pixel_frame_assembler_if.slave bus
);

    state_t                       r_state;
    logic                         r_run;
    logic [COL_W-1:0]             r_col;
    logic [ROW_W-1:0]             r_row;
    logic signed [RESOLUTION-1:0] r_prev;
    logic signed [RESOLUTION:0]   r_psum [AVG_W];
    logic signed [RESOLUTION-1:0] r_out  [AVG_PIX];
    logic                         r_frame_err;

    logic                         w_beat;
    logic                         w_last_col;
    logic                         w_last_row;
    logic                         w_final;
    logic                         w_early_last;
    logic                         w_store;
    logic                         w_psum_we;
    logic                         w_out_we;
    logic [PAIR_W-1:0]            w_pair;
    logic [BAND_W-1:0]            w_band;
    logic [K_W-1:0]               w_k;
    logic signed [RESOLUTION-1:0] w_pool;

    // s_ready stays low for the first cycle out of reset.
    assign bus.s_ready     = r_run && (r_state == ST_FILL);
    assign bus.frame_valid = (r_state == ST_HOLD);
    assign bus.frame_err   = r_frame_err;

    assign w_beat       = bus.s_valid && bus.s_ready;
    assign w_last_col   = (r_col == COL_W'(IMG_W - 1));
    assign w_last_row   = (r_row == ROW_W'(IMG_H - 1));
    assign w_final      = w_last_col && w_last_row;
    assign w_early_last = bus.s_last && !w_final;

    assign w_store   = w_beat && !w_early_last && r_col[0];
    assign w_psum_we = w_store && !r_row[0];
    assign w_out_we  = w_store && r_row[0];

    assign w_pair = r_col[COL_W-1:1];
    assign w_band = r_row[ROW_W-1:1];
    assign w_k    = pool_index(w_band, w_pair);

    pool_sum_unit u_pool (
        .i_psum (r_psum[w_pair]),
        .i_a    (r_prev),
        .i_b    (bus.s_pixel),
        .o_pool (w_pool)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_FILL;
            r_run       <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_prev      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_state == ST_HOLD) begin
                if (bus.frame_ready) begin
                    r_state <= ST_FILL;
                end
            end else if (w_beat) begin
                if (w_early_last) begin
                    // Premature s_last: discard the beat and restart the frame.
                    r_frame_err <= 1'b1;
                    r_col       <= '0;
                    r_row       <= '0;
                end else begin
                    if (w_final && !bus.s_last) begin
                        r_frame_err <= 1'b1;
                    end
                    if (!r_col[0]) begin
                        r_prev <= bus.s_pixel;
                    end
                    if (w_last_col) begin
                        r_col <= '0;
                        r_row <= w_last_row ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    if (w_final) begin
                        r_state <= ST_HOLD;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < AVG_W; i++) begin
                r_psum[i] <= '0;
            end
            for (int j = 0; j < AVG_PIX; j++) begin
                r_out[j] <= '0;
            end
        end else begin
            if (w_psum_we) begin
                r_psum[w_pair] <= {r_prev[RESOLUTION-1], r_prev}
                                + {bus.s_pixel[RESOLUTION-1], bus.s_pixel};
            end
            if (w_out_we) begin
                r_out[w_k] <= w_pool;
            end
        end
    end

    generate
        for (genvar g = 0; g < AVG_PIX; g++) begin : g_flat
            assign bus.pixels[RESOLUTION*g +: RESOLUTION] = r_out[g];
        end
    endgenerate

endmodule
`default_nettype wire
